// File: rtl/tbots_arb_pkg.sv
// Shared types and default sizing for the arbitrated SPI port.
package tbots_arb_pkg;

    localparam int unsigned DEF_WIDTH   = 5;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_CLK_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK divider: emits one-cycle rise/fall ticks every CLK_DIV cycles while enabled.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic hostCLK,
    input  logic reset,
    input  logic en,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] div_cnt;
    logic             phase;
    logic             tick_c;

    // phase=0 means the next tick raises sclk
    assign tick_c      = en && (div_cnt == CNT_W'(CLK_DIV - 1));
    assign rise_tick_c = tick_c && !phase;
    assign fall_tick_c = tick_c && phase;

    always_ff @(posedge hostCLK or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (tick_c) begin
            div_cnt <= '0;
            phase   <= !phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arb_spi_port.sv
// SPI mode-0 master shared by round-robin arbitrated users.
// Optional sticky multi-hot grant check enabled by macro ARB_SPI_GRANT_CHECK_EN.
module arb_spi_port
    import tbots_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic                    hostCLK,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        grant,
    input  logic [WIDTH*DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0]       rx_data,
    output logic [WIDTH-1:0]        done,
    output logic                    busy,
    output logic                    sclk,
    output logic                    mosi,
    output logic                    cs_n,
    input  logic                    miso
`ifdef ARB_SPI_GRANT_CHECK_EN
    ,
    output logic                    grant_err
`endif
);

    localparam int unsigned OWN_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    arb_state_e        state, state_nxt;
    logic [OWN_W-1:0]  owner, owner_nxt;
    logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
    logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] rx_data_nxt;
    logic [WIDTH-1:0]  done_nxt;
    logic              busy_nxt, sclk_nxt, mosi_nxt, cs_n_nxt;

    logic [OWN_W-1:0]  sel_idx_c;
    logic [DATA_W-1:0] sel_word_c;
    logic              rise_tick_c, fall_tick_c;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .hostCLK     (hostCLK),
        .reset       (reset),
        .en          (state == ST_SHIFT),
        .rise_tick_c (rise_tick_c),
        .fall_tick_c (fall_tick_c)
    );

    // Lowest set grant index wins; descending scan lets the lowest overwrite.
    always_comb begin
        sel_idx_c  = '0;
        sel_word_c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (grant[i]) begin
                sel_idx_c  = OWN_W'(i);
                sel_word_c = tx_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge hostCLK or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            done     <= '0;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            tx_shift <= tx_shift_nxt;
            rx_shift <= rx_shift_nxt;
            bit_cnt  <= bit_cnt_nxt;
            rx_data  <= rx_data_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
            sclk     <= sclk_nxt;
            mosi     <= mosi_nxt;
            cs_n     <= cs_n_nxt;
        end
    end

    // Outputs are registered from the decoded next state.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        bit_cnt_nxt  = bit_cnt;
        rx_data_nxt  = rx_data;
        done_nxt     = '0;
        sclk_nxt     = sclk;
        mosi_nxt     = mosi;
        cs_n_nxt     = cs_n;

        unique case (state)
            ST_IDLE: begin
                sclk_nxt = 1'b0;
                cs_n_nxt = 1'b1;
                mosi_nxt = 1'b0;
                if (|grant) begin
                    owner_nxt    = sel_idx_c;
                    tx_shift_nxt = sel_word_c;
                    rx_shift_nxt = '0;
                    bit_cnt_nxt  = '0;
                    mosi_nxt     = sel_word_c[DATA_W-1];
                    cs_n_nxt     = 1'b0;
                    state_nxt    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!grant[owner]) begin
                    // owner withdrew: abort silently
                    state_nxt = ST_IDLE;
                    cs_n_nxt  = 1'b1;
                    sclk_nxt  = 1'b0;
                    mosi_nxt  = 1'b0;
                end else if (rise_tick_c) begin
                    sclk_nxt     = 1'b1;
                    rx_shift_nxt = {rx_shift[DATA_W-2:0], miso};
                end else if (fall_tick_c) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        state_nxt       = ST_DONE;
                        cs_n_nxt        = 1'b1;
                        mosi_nxt        = 1'b0;
                        rx_data_nxt     = rx_shift;
                        done_nxt[owner] = 1'b1;
                    end else begin
                        bit_cnt_nxt  = bit_cnt + 1'b1;
                        tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
                        mosi_nxt     = tx_shift[DATA_W-2];
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!grant[owner]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

`ifdef ARB_SPI_GRANT_CHECK_EN
    // Sticky flag for more than one grant bit high in any cycle.
    always_ff @(posedge hostCLK or posedge reset) begin
        if (reset) begin
            grant_err <= 1'b0;
        end else if ((grant & (grant - 1'b1)) != '0) begin
            grant_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_spi_port.sv
// Directed self-checking bench for arb_spi_port with mosi looped back to miso.
`timescale 1ns/1ps
module tb_arb_spi_port;

    localparam int unsigned WIDTH   = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CLK_DIV = 4;

    logic                    hostCLK;
    logic                    reset;
    logic [WIDTH-1:0]        grant;
    logic [WIDTH*DATA_W-1:0] tx_data;
    logic [DATA_W-1:0]       rx_data;
    logic [WIDTH-1:0]        done;
    logic                    busy;
    logic                    sclk;
    logic                    mosi;
    logic                    cs_n;
    logic                    miso;
`ifdef ARB_SPI_GRANT_CHECK_EN
    logic                    grant_err;
`endif

    int checks = 0;
    int errors = 0;

    assign miso = mosi;

    arb_spi_port #(
        .WIDTH   (WIDTH),
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .hostCLK (hostCLK),
        .reset   (reset),
        .grant   (grant),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .done    (done),
        .busy    (busy),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs_n    (cs_n),
        .miso    (miso)
`ifdef ARB_SPI_GRANT_CHECK_EN
        ,
        .grant_err (grant_err)
`endif
    );

    initial hostCLK = 1'b0;
    always #6.25 hostCLK = ~hostCLK;

    // Waits for any done pulse; cycles = -1 on timeout.
    task automatic wait_for_done(input int budget, output int cycles);
        cycles = 0;
        while (done === '0 && cycles < budget) begin
            @(negedge hostCLK);
            cycles++;
        end
        if (done === '0) cycles = -1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        grant   = '0;
        tx_data = '0;
        repeat (2) @(negedge hostCLK);
        checks++; if (cs_n !== 1'b1)   begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (sclk !== 1'b0)   begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0)   begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (done !== 5'b0)   begin errors++; $display("FAIL reset_done: got %b expected 00000", done); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx: got %h expected 0000", rx_data); end
`ifdef ARB_SPI_GRANT_CHECK_EN
        checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL reset_grant_err: got %b expected 0", grant_err); end
`endif
        reset = 1'b0;
        @(negedge hostCLK);
    endtask

    // User 2 loopback transfer; mid-shift changes to tx_data and other grants are ignored.
    task automatic test_loopback();
        int cnt;
        int rises;
        logic prev_sclk;
        tx_data = '0;
        tx_data[0*DATA_W +: DATA_W] = 16'h1111;
        tx_data[1*DATA_W +: DATA_W] = 16'h2222;
        tx_data[2*DATA_W +: DATA_W] = 16'hA55A;
        tx_data[3*DATA_W +: DATA_W] = 16'h4444;
        grant = 5'b00100;
        @(negedge hostCLK);
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL lb_cs_fall: got %b expected 0", cs_n); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL lb_mosi_msb: got %b expected 1", mosi); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lb_busy: got %b expected 1", busy); end
        cnt = 0;
        rises = 0;
        prev_sclk = 1'b0;
        while (cs_n === 1'b0 && cnt < 1000) begin
            cnt++;
            if (!prev_sclk && sclk) rises++;
            prev_sclk = sclk;
            if (cnt == 50) begin
                tx_data[2*DATA_W +: DATA_W] = 16'h0000;
                grant = 5'b00110;
            end
            @(negedge hostCLK);
        end
        checks++; if (cnt != 128) begin errors++; $display("FAIL lb_cs_low_cycles: got %0d expected 128", cnt); end
        checks++; if (rises != 16) begin errors++; $display("FAIL lb_sclk_rises: got %0d expected 16", rises); end
        checks++; if (done !== 5'b00100) begin errors++; $display("FAIL lb_done: got %b expected 00100", done); end
        checks++; if (rx_data !== 16'hA55A) begin errors++; $display("FAIL lb_rx: got %h expected a55a", rx_data); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL lb_sclk_idle: got %b expected 0", sclk); end
        @(negedge hostCLK);
        checks++; if (done !== 5'b0) begin errors++; $display("FAIL lb_done_pulse: got %b expected 00000", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lb_release_busy: got %b expected 1", busy); end
        grant = 5'b0;
        @(negedge hostCLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lb_idle: got %b expected 0", busy); end
    endtask

    // User 1 holds grant for 300 cycles after done: no second transfer.
    task automatic test_hold_release();
        int cyc;
        int extra_done;
        int cs_low;
        int idle_seen;
        tx_data[1*DATA_W +: DATA_W] = 16'h3C96;
        grant = 5'b00010;
        @(negedge hostCLK);
        wait_for_done(400, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL hold_done_timeout: got none expected done"); end
        checks++; if (done !== 5'b00010) begin errors++; $display("FAIL hold_done: got %b expected 00010", done); end
        checks++; if (rx_data !== 16'h3C96) begin errors++; $display("FAIL hold_rx: got %h expected 3c96", rx_data); end
        extra_done = 0;
        cs_low = 0;
        idle_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge hostCLK);
            if (done !== 5'b0) extra_done++;
            if (cs_n !== 1'b1) cs_low++;
            if (busy !== 1'b1) idle_seen++;
        end
        checks++; if (extra_done != 0) begin errors++; $display("FAIL hold_extra_done: got %0d expected 0", extra_done); end
        checks++; if (cs_low != 0) begin errors++; $display("FAIL hold_cs_low: got %0d expected 0", cs_low); end
        checks++; if (idle_seen != 0) begin errors++; $display("FAIL hold_left_release: got %0d expected 0", idle_seen); end
        grant = 5'b0;
        @(negedge hostCLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got %b expected 0", busy); end
    endtask

    // User 3 drops grant at SHIFT cycle 40: abort, rx_data keeps 3C96.
    task automatic test_abort();
        logic [WIDTH-1:0] done_acc;
        tx_data[3*DATA_W +: DATA_W] = 16'h0F0F;
        grant = 5'b01000;
        @(negedge hostCLK);
        repeat (40) @(negedge hostCLK);
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL abort_in_shift: got %b expected 0", cs_n); end
        grant = 5'b0;
        @(negedge hostCLK);
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b expected 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        done_acc = done;
        for (int i = 0; i < 20; i++) begin
            @(negedge hostCLK);
            done_acc = done_acc | done;
        end
        checks++; if (done_acc !== 5'b0) begin errors++; $display("FAIL abort_done: got %b expected 00000", done_acc); end
        checks++; if (rx_data !== 16'h3C96) begin errors++; $display("FAIL abort_rx: got %h expected 3c96", rx_data); end
    endtask

    // Grant hands from user0 to user1 in one cycle; second cs_n fall two cycles later.
    task automatic test_back_to_back();
        int cyc;
        int cnt;
        logic first_idle_cs;
        tx_data[0*DATA_W +: DATA_W] = 16'h1357;
        tx_data[1*DATA_W +: DATA_W] = 16'hBEEF;
        grant = 5'b00001;
        @(negedge hostCLK);
        wait_for_done(400, cyc);
        checks++; if (done !== 5'b00001) begin errors++; $display("FAIL b2b_done0: got %b expected 00001", done); end
        checks++; if (rx_data !== 16'h1357) begin errors++; $display("FAIL b2b_rx0: got %h expected 1357", rx_data); end
        @(negedge hostCLK);
        grant = 5'b00010;
        cnt = 0;
        first_idle_cs = 1'b0;
        while (cs_n !== 1'b0 && cnt < 10) begin
            @(negedge hostCLK);
            cnt++;
            if (cnt == 1) first_idle_cs = cs_n;
        end
        checks++; if (cnt != 2) begin errors++; $display("FAIL b2b_cs_fall_delay: got %0d expected 2", cnt); end
        checks++; if (first_idle_cs !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 1", first_idle_cs); end
        wait_for_done(400, cyc);
        checks++; if (done !== 5'b00010) begin errors++; $display("FAIL b2b_done1: got %b expected 00010", done); end
        checks++; if (rx_data !== 16'hBEEF) begin errors++; $display("FAIL b2b_rx1: got %h expected beef", rx_data); end
        grant = 5'b0;
        repeat (2) @(negedge hostCLK);
    endtask

    // Reset mid-SHIFT clears everything at once; a transfer starts on the first edge after.
    task automatic test_reset_mid_shift();
        logic [WIDTH-1:0] done_acc;
        grant = 5'b00100;
        @(negedge hostCLK);
        repeat (30) @(negedge hostCLK);
        reset = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n: got %b expected 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mid_mosi: got %b expected 0", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (done !== 5'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 00000", done); end
        checks++; if (rx_data !== 16'h0) begin errors++; $display("FAIL rst_mid_rx: got %h expected 0000", rx_data); end
        repeat (2) @(negedge hostCLK);
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_hold_cs_n: got %b expected 1", cs_n); end
        reset = 1'b0;
        @(negedge hostCLK);
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL rst_first_start: got %b expected 0", cs_n); end
        grant = 5'b0;
        done_acc = '0;
        for (int i = 0; i < 150; i++) begin
            @(negedge hostCLK);
            done_acc = done_acc | done;
        end
        checks++; if (done_acc !== 5'b0) begin errors++; $display("FAIL rst_no_done: got %b expected 00000", done_acc); end
    endtask

`ifdef ARB_SPI_GRANT_CHECK_EN
    task automatic test_grant_err();
        int cyc;
        checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL gerr_clear: got %b expected 0", grant_err); end
        tx_data[0*DATA_W +: DATA_W] = 16'h600D;
        grant = 5'b01001;
        @(negedge hostCLK);
        grant = 5'b00001;
        checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL gerr_set: got %b expected 1", grant_err); end
        wait_for_done(400, cyc);
        checks++; if (done !== 5'b00001) begin errors++; $display("FAIL gerr_owner: got %b expected 00001", done); end
        checks++; if (rx_data !== 16'h600D) begin errors++; $display("FAIL gerr_rx: got %h expected 600d", rx_data); end
        checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL gerr_sticky: got %b expected 1", grant_err); end
        grant = 5'b0;
        reset = 1'b1;
        @(negedge hostCLK);
        checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL gerr_reset: got %b expected 0", grant_err); end
        reset = 1'b0;
        @(negedge hostCLK);
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_hold_release();
        test_abort();
        test_back_to_back();
        test_reset_mid_shift();
`ifdef ARB_SPI_GRANT_CHECK_EN
        test_grant_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
